// File: rtl/opnd_fetch_pkg.sv
// Shared encodings for the operand-fetch stage:
// operand forms, GPR indices, destination kinds and FSM states.
package opnd_fetch_pkg;

    localparam logic [3:0] OPND_ENC_NONE               = 4'd0;
    localparam logic [3:0] OPND_ENC_IMM                = 4'd1;
    localparam logic [3:0] OPND_ENC_RM_REG             = 4'd2;
    localparam logic [3:0] OPND_ENC_REG_RM             = 4'd3;
    localparam logic [3:0] OPND_ENC_RM_IMM             = 4'd4;
    localparam logic [3:0] OPND_ENC_MODREGRM_RM_REG_CL = 4'd5;
    localparam logic [3:0] OPND_ENC_DISP               = 4'd6;

    localparam logic [2:0] REG_EAX = 3'd0;
    localparam logic [2:0] REG_ECX = 3'd1;
    localparam logic [2:0] REG_EDX = 3'd2;
    localparam logic [2:0] REG_EBX = 3'd3;
    localparam logic [2:0] REG_ESP = 3'd4;
    localparam logic [2:0] REG_EBP = 3'd5;
    localparam logic [2:0] REG_ESI = 3'd6;
    localparam logic [2:0] REG_EDI = 3'd7;

    localparam logic [1:0] OPND_DEST_REG = 2'd0;
    localparam logic [1:0] OPND_DEST_MEM = 2'd1;

    typedef enum logic [2:0] {
        FETCH_ST_IDLE  = 3'd0,
        FETCH_ST_CALC  = 3'd1,
        FETCH_ST_MREQ  = 3'd2,
        FETCH_ST_MWAIT = 3'd3,
        FETCH_ST_DONE  = 3'd4
    } fetch_st_e;

    function automatic logic enc_has_modrm(input logic [3:0] f);
        return (f == OPND_ENC_RM_REG) || (f == OPND_ENC_REG_RM) ||
               (f == OPND_ENC_RM_IMM) ||
               (f == OPND_ENC_MODREGRM_RM_REG_CL);
    endfunction

endpackage

// File: rtl/opnd_fetch_modrm_ea.sv
// ModR/M + SIB effective-address decoder (combinational).
// tail holds the instruction bytes that follow ModR/M.
module opnd_fetch_modrm_ea
    import opnd_fetch_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  has_modrm,
    input  logic                  addr16,
    input  logic [7:0]            modrm,
    input  logic [39:0]           tail,
    input  logic [8*WORD_W-1:0]   regs,
    output logic [ADDR_W-1:0]     ea,
    output logic                  has_sib,
    output logic [2:0]            disp_bytes,
    output logic                  mem_opnd
);

    logic [1:0]  mod;
    logic [2:0]  rm;
    logic [7:0]  sib;
    logic [31:0] dsrc;
    logic [31:0] base;
    logic [31:0] index;
    logic [31:0] disp;
    logic [31:0] sum;
    logic        no_base;

    function automatic logic [31:0] gpr(input logic [2:0] n);
        return 32'(regs[int'(n)*WORD_W +: WORD_W]);
    endfunction

    function automatic logic [31:0] gpr16(input logic [2:0] n);
        return {16'b0, regs[int'(n)*WORD_W +: 16]};
    endfunction

    function automatic logic [31:0] sx8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    // Decode addressing mode and sum base + scaled index + displacement
    always_comb begin
        mod        = modrm[7:6];
        rm         = modrm[2:0];
        sib        = tail[7:0];
        has_sib    = 1'b0;
        disp_bytes = 3'd0;
        dsrc       = tail[31:0];
        base       = '0;
        index      = '0;
        disp       = '0;
        sum        = '0;
        no_base    = 1'b0;
        mem_opnd   = has_modrm && (mod != 2'b11);
        if (mem_opnd && addr16) begin
            unique case (rm)
                3'd0: begin base = gpr16(REG_EBX); index = gpr16(REG_ESI); end
                3'd1: begin base = gpr16(REG_EBX); index = gpr16(REG_EDI); end
                3'd2: begin base = gpr16(REG_EBP); index = gpr16(REG_ESI); end
                3'd3: begin base = gpr16(REG_EBP); index = gpr16(REG_EDI); end
                3'd4: base = gpr16(REG_ESI);
                3'd5: base = gpr16(REG_EDI);
                3'd6: base = (mod == 2'b00) ? '0 : gpr16(REG_EBP);
                default: base = gpr16(REG_EBX);
            endcase
            if (mod == 2'b01) begin
                disp_bytes = 3'd1;
                disp       = sx8(tail[7:0]);
            end else if (mod == 2'b10 || rm == 3'd6) begin
                disp_bytes = 3'd2;
                disp       = {16'b0, tail[15:0]};
            end
            sum = {16'b0, 16'(base + index + disp)};
        end else if (mem_opnd) begin
            has_sib = (rm == 3'd4);
            dsrc    = has_sib ? tail[39:8] : tail[31:0];
            no_base = (mod == 2'b00) &&
                      (has_sib ? (sib[2:0] == 3'd5) : (rm == 3'd5));
            base    = no_base ? '0 : gpr(has_sib ? sib[2:0] : rm);
            if (has_sib && sib[5:3] != 3'd4)
                index = gpr(sib[5:3]) << sib[7:6];
            if (mod == 2'b01) begin
                disp_bytes = 3'd1;
                disp       = sx8(dsrc[7:0]);
            end else if (mod == 2'b10 || no_base) begin
                disp_bytes = 3'd4;
                disp       = dsrc;
            end
            sum = base + index + disp;
        end
        ea = ADDR_W'(sum);
    end

endmodule

// File: rtl/opnd_fetch.sv
// Operand-fetch stage: latches a decoded instruction, resolves
// register/immediate/memory operands and hands them to execute.
module opnd_fetch
    import opnd_fetch_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int NUM_OPNDS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [71:0]                   unescaped_instr,
    input  logic [8*WORD_W-1:0]           regs,
    input  logic [3:0]                    opnd_form,
    input  logic                          imm_1byte,
    input  logic                          reg_1byte,
    input  logic                          prefix_operand_16bit,
    input  logic                          prefix_address_16bit,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic [ADDR_W-1:0]             mem_req_addr,
    input  logic                          mem_rsp_valid,
    input  logic [WORD_W-1:0]             mem_rsp_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_OPNDS*WORD_W-1:0]   opnd_r,
    output logic [ADDR_W-1:0]             ea,
    output logic [1:0]                    dest0_kind,
    output logic [1:0]                    dest1_kind,
    output logic                          err
);

    fetch_st_e                    state_q, state_d;
    logic [71:0]                  instr_q, instr_d;
    logic [8*WORD_W-1:0]          regs_q, regs_d;
    logic [3:0]                   form_q, form_d;
    logic                         imm1_q, imm1_d;
    logic                         r1_q, r1_d;
    logic                         op16_q, op16_d;
    logic                         a16_q, a16_d;
    logic [NUM_OPNDS*WORD_W-1:0]  opnd_q, opnd_d;
    logic [ADDR_W-1:0]            ea_q, ea_d;
    logic [1:0]                   d0_q, d0_d;
    logic [1:0]                   d1_q, d1_d;
    logic                         err_q, err_d;
    logic                         rm_slot_q, rm_slot_d;

    logic                         has_modrm;
    logic [ADDR_W-1:0]            ea_c;
    logic                         has_sib_c;
    logic [2:0]                   disp_bytes_c;
    logic                         mem_c;
    logic [3:0]                   imm_off;
    logic [159:0]                 ibuf;
    logic [31:0]                  imm_raw;
    logic [WORD_W-1:0]            imm_v;
    logic [WORD_W-1:0]            rm_v;
    logic [WORD_W-1:0]            rg_v;

    assign has_modrm = enc_has_modrm(form_q);

    opnd_fetch_modrm_ea #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_modrm_ea (
        .has_modrm  (has_modrm),
        .addr16     (a16_q),
        .modrm      (instr_q[15:8]),
        .tail       (instr_q[55:16]),
        .regs       (regs_q),
        .ea         (ea_c),
        .has_sib    (has_sib_c),
        .disp_bytes (disp_bytes_c),
        .mem_opnd   (mem_c)
    );

    function automatic logic [WORD_W-1:0] reg_opnd(input logic [2:0] sel);
        logic [WORD_W-1:0] r;
        logic [WORD_W-1:0] rb;
        r  = regs_q[int'(sel)*WORD_W +: WORD_W];
        rb = regs_q[int'({1'b0, sel[1:0]})*WORD_W +: WORD_W];
        if (r1_q)
            return WORD_W'(sel[2] ? rb[15:8] : rb[7:0]);
        if (op16_q)
            return WORD_W'(r[15:0]);
        return r;
    endfunction

    function automatic logic [WORD_W-1:0] mem_opnd(input logic [WORD_W-1:0] d);
        if (r1_q)
            return WORD_W'(d[7:0]);
        if (op16_q)
            return WORD_W'(d[15:0]);
        return d;
    endfunction

    // Immediate follows opcode, ModR/M, SIB and displacement
    always_comb begin
        imm_off = 4'd1 + 4'(has_modrm) + 4'(has_sib_c) + 4'(disp_bytes_c);
        ibuf    = {88'b0, instr_q};
        imm_raw = ibuf[{imm_off, 3'b000} +: 32];
        if (imm1_q)
            imm_v = r1_q ? WORD_W'(imm_raw[7:0])
                         : WORD_W'({{24{imm_raw[7]}}, imm_raw[7:0]});
        else if (op16_q)
            imm_v = WORD_W'(imm_raw[15:0]);
        else
            imm_v = WORD_W'(imm_raw);
        rm_v = mem_c ? '0 : reg_opnd(instr_q[10:8]);
        rg_v = reg_opnd(instr_q[13:11]);
    end

    // Next-state and datapath update for the fetch FSM
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        regs_d    = regs_q;
        form_d    = form_q;
        imm1_d    = imm1_q;
        r1_d      = r1_q;
        op16_d    = op16_q;
        a16_d     = a16_q;
        opnd_d    = opnd_q;
        ea_d      = ea_q;
        d0_d      = d0_q;
        d1_d      = d1_q;
        err_d     = err_q;
        rm_slot_d = rm_slot_q;
        unique case (state_q)
            FETCH_ST_IDLE: begin
                if (in_valid) begin
                    instr_d = unescaped_instr;
                    regs_d  = regs;
                    form_d  = opnd_form;
                    imm1_d  = imm_1byte;
                    r1_d    = reg_1byte;
                    op16_d  = prefix_operand_16bit;
                    a16_d   = prefix_address_16bit;
                    state_d = FETCH_ST_CALC;
                end
            end
            FETCH_ST_CALC: begin
                opnd_d    = '0;
                ea_d      = '0;
                d0_d      = OPND_DEST_REG;
                d1_d      = OPND_DEST_REG;
                err_d     = 1'b0;
                rm_slot_d = 1'b0;
                unique case (form_q)
                    OPND_ENC_NONE: ;
                    OPND_ENC_IMM:
                        opnd_d[0 +: WORD_W] = imm_v;
                    OPND_ENC_RM_REG: begin
                        opnd_d[0 +: WORD_W]      = rm_v;
                        opnd_d[WORD_W +: WORD_W] = rg_v;
                    end
                    OPND_ENC_MODREGRM_RM_REG_CL: begin
                        opnd_d[0 +: WORD_W]        = rm_v;
                        opnd_d[WORD_W +: WORD_W]   = rg_v;
                        opnd_d[2*WORD_W +: WORD_W] =
                            WORD_W'(regs_q[int'(REG_ECX)*WORD_W +: 8]);
                    end
                    OPND_ENC_REG_RM: begin
                        opnd_d[0 +: WORD_W]      = rg_v;
                        opnd_d[WORD_W +: WORD_W] = rm_v;
                        rm_slot_d                = 1'b1;
                    end
                    OPND_ENC_RM_IMM: begin
                        opnd_d[0 +: WORD_W]      = rm_v;
                        opnd_d[WORD_W +: WORD_W] = imm_v;
                    end
                    default: err_d = 1'b1;
                endcase
                if (!err_d && mem_c) begin
                    ea_d = ea_c;
                    if (rm_slot_d)
                        d1_d = OPND_DEST_MEM;
                    else
                        d0_d = OPND_DEST_MEM;
                    state_d = FETCH_ST_MREQ;
                end else begin
                    state_d = FETCH_ST_DONE;
                end
            end
            FETCH_ST_MREQ: begin
                if (mem_req_ready)
                    state_d = FETCH_ST_MWAIT;
            end
            FETCH_ST_MWAIT: begin
                if (mem_rsp_valid) begin
                    if (rm_slot_q)
                        opnd_d[WORD_W +: WORD_W] = mem_opnd(mem_rsp_data);
                    else
                        opnd_d[0 +: WORD_W] = mem_opnd(mem_rsp_data);
                    state_d = FETCH_ST_DONE;
                end
            end
            FETCH_ST_DONE: begin
                if (out_ready)
                    state_d = FETCH_ST_IDLE;
            end
            default: state_d = FETCH_ST_IDLE;
        endcase
    end

    // State and operand registers; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH_ST_IDLE;
            instr_q   <= '0;
            regs_q    <= '0;
            form_q    <= '0;
            imm1_q    <= 1'b0;
            r1_q      <= 1'b0;
            op16_q    <= 1'b0;
            a16_q     <= 1'b0;
            opnd_q    <= '0;
            ea_q      <= '0;
            d0_q      <= OPND_DEST_REG;
            d1_q      <= OPND_DEST_REG;
            err_q     <= 1'b0;
            rm_slot_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            regs_q    <= regs_d;
            form_q    <= form_d;
            imm1_q    <= imm1_d;
            r1_q      <= r1_d;
            op16_q    <= op16_d;
            a16_q     <= a16_d;
            opnd_q    <= opnd_d;
            ea_q      <= ea_d;
            d0_q      <= d0_d;
            d1_q      <= d1_d;
            err_q     <= err_d;
            rm_slot_q <= rm_slot_d;
        end
    end

    assign in_ready      = (state_q == FETCH_ST_IDLE);
    assign mem_req_valid = (state_q == FETCH_ST_MREQ);
    assign mem_req_addr  = mem_req_valid ? ea_q : '0;
    assign out_valid     = (state_q == FETCH_ST_DONE);
    assign opnd_r        = opnd_q;
    assign ea            = ea_q;
    assign dest0_kind    = d0_q;
    assign dest1_kind    = d1_q;
    assign err           = err_q;

endmodule

// File: tb/tb_opnd_fetch.sv
// Directed scoreboard bench for opnd_fetch.
// Expected results are queued at issue and checked at out_valid.
module tb_opnd_fetch;
    import opnd_fetch_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [71:0]  unescaped_instr = '0;
    logic [255:0] regs;
    logic [3:0]   opnd_form = '0;
    logic         imm_1byte = 1'b0;
    logic         reg_1byte = 1'b0;
    logic         prefix_operand_16bit = 1'b0;
    logic         prefix_address_16bit = 1'b0;
    logic         mem_req_valid;
    logic         mem_req_ready = 1'b0;
    logic [31:0]  mem_req_addr;
    logic         mem_rsp_valid = 1'b0;
    logic [31:0]  mem_rsp_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [95:0]  opnd_r;
    logic [31:0]  ea;
    logic [1:0]   dest0_kind;
    logic [1:0]   dest1_kind;
    logic         err;

    logic [31:0]  gpr [8];

    typedef struct {
        logic [95:0] opnd;
        logic [31:0] ea;
        logic [1:0]  d0;
        logic [1:0]  d1;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    assign regs = {gpr[7], gpr[6], gpr[5], gpr[4],
                   gpr[3], gpr[2], gpr[1], gpr[0]};

    opnd_fetch dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .unescaped_instr      (unescaped_instr),
        .regs                 (regs),
        .opnd_form            (opnd_form),
        .imm_1byte            (imm_1byte),
        .reg_1byte            (reg_1byte),
        .prefix_operand_16bit (prefix_operand_16bit),
        .prefix_address_16bit (prefix_address_16bit),
        .mem_req_valid        (mem_req_valid),
        .mem_req_ready        (mem_req_ready),
        .mem_req_addr         (mem_req_addr),
        .mem_rsp_valid        (mem_rsp_valid),
        .mem_rsp_data         (mem_rsp_data),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .opnd_r               (opnd_r),
        .ea                   (ea),
        .dest0_kind           (dest0_kind),
        .dest1_kind           (dest1_kind),
        .err                  (err)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [95:0] obs,
                       input logic [95:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] o0, input logic [31:0] o1,
                                input logic [31:0] o2, input logic [31:0] a,
                                input logic [1:0] d0, input logic [1:0] d1,
                                input logic e);
        exp_t x;
        x.opnd = {o2, o1, o0};
        x.ea   = a;
        x.d0   = d0;
        x.d1   = d1;
        x.err  = e;
        return x;
    endfunction

    // flags = {imm_1byte, reg_1byte, prefix_operand_16bit, prefix_address_16bit}
    task automatic run(input string tag, input logic [71:0] ins,
                       input logic [3:0] form, input logic [3:0] flags,
                       input logic is_mem, input logic [31:0] addr,
                       input logic [31:0] rdata, input int req_stall,
                       input int rsp_wait, input int hold,
                       input int lat_exp, input exp_t e);
        int   n;
        int   lat;
        logic stable;
        exp_t got;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "/in_ready"}, 96'(in_ready), 96'd1);
        unescaped_instr = ins;
        opnd_form = form;
        {imm_1byte, reg_1byte, prefix_operand_16bit,
         prefix_address_16bit} = flags;
        in_valid = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        if (is_mem) begin
            n = 0;
            while (!mem_req_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk({tag, "/req_addr"}, 96'(mem_req_addr), 96'(addr));
            stable = mem_req_valid;
            for (int i = 0; i < req_stall; i++) begin
                @(negedge clk);
                if (!mem_req_valid || mem_req_addr !== addr)
                    stable = 1'b0;
            end
            chk({tag, "/req_stable"}, 96'(stable), 96'd1);
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            for (int i = 0; i < rsp_wait; i++)
                @(negedge clk);
            chk({tag, "/early_out"}, 96'(out_valid), 96'd0);
            mem_rsp_valid = 1'b1;
            mem_rsp_data = rdata;
            @(negedge clk);
            mem_rsp_valid = 1'b0;
        end
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "/out_valid"}, 96'(out_valid), 96'd1);
        if (lat_exp > 0)
            chk({tag, "/latency"}, 96'(lat), 96'(lat_exp));
        got = sb.pop_front();
        chk({tag, "/opnd"}, opnd_r, got.opnd);
        chk({tag, "/ea"}, 96'(ea), 96'(got.ea));
        chk({tag, "/dest"}, 96'({dest1_kind, dest0_kind}),
            96'({got.d1, got.d0}));
        chk({tag, "/err"}, 96'(err), 96'(got.err));
        if (hold > 0) begin
            stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!out_valid || opnd_r !== got.opnd)
                    stable = 1'b0;
            end
            chk({tag, "/hold"}, 96'(stable), 96'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "/once"}, 96'({out_valid, in_ready}), 96'b01);
    endtask

    initial begin
        logic stable;
        int   n;
        for (int i = 0; i < 8; i++)
            gpr[i] = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("reset/in_ready", 96'(in_ready), 96'd1);
        chk("reset/outs", 96'({out_valid, mem_req_valid, err,
                               dest0_kind, dest1_kind}), 96'd0);
        chk("reset/opnd", opnd_r, 96'd0);
        chk("reset/ea", 96'(ea), 96'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD EAX,EBX register form
        gpr[0] = 32'd5;
        gpr[3] = 32'd7;
        run("regreg", 72'hD801, OPND_ENC_RM_REG, 4'b0000, 1'b0, 0, 0,
            0, 0, 0, 2, mk(5, 7, 0, 0, OPND_DEST_REG, OPND_DEST_REG, 0));

        // SIB + disp8: [EBX + ECX*4 - 4]
        gpr[0] = 32'h11;
        gpr[1] = 32'd2;
        gpr[3] = 32'h1000;
        run("sib", 72'hFC8B448B, OPND_ENC_REG_RM, 4'b0000, 1'b1,
            32'h1004, 32'hDEAD, 0, 0, 0, 0,
            mk(32'h11, 32'hDEAD, 0, 32'h1004,
               OPND_DEST_REG, OPND_DEST_MEM, 0));

        // same with request stall, response delay and output backpressure
        run("stall", 72'hFC8B448B, OPND_ENC_REG_RM, 4'b0000, 1'b1,
            32'h1004, 32'h5A5A, 3, 4, 2, 0,
            mk(32'h11, 32'h5A5A, 0, 32'h1004,
               OPND_DEST_REG, OPND_DEST_MEM, 0));

        // ADD AH,imm8 with byte registers
        gpr[0] = 32'h1234;
        run("ah_imm8", 72'hFFC480, OPND_ENC_RM_IMM, 4'b1100, 1'b0, 0, 0,
            0, 0, 0, 2, mk(32'h12, 32'hFF, 0, 0,
                           OPND_DEST_REG, OPND_DEST_REG, 0));

        // sign-extended imm8 into a 32-bit operand
        run("simm8", 72'hFFC083, OPND_ENC_RM_IMM, 4'b1000, 1'b0, 0, 0,
            0, 0, 0, 2, mk(32'h1234, 32'hFFFF_FFFF, 0, 0,
                           OPND_DEST_REG, OPND_DEST_REG, 0));

        // 16-bit addressing [BX+SI+2] wraps at 64K
        gpr[3] = 32'h10;
        gpr[6] = 32'hFFFF;
        run("addr16", 72'h02408B, OPND_ENC_REG_RM, 4'b0001, 1'b1,
            32'h0011, 32'hBEEF, 0, 1, 0, 0,
            mk(32'h1234, 32'hBEEF, 0, 32'h0011,
               OPND_DEST_REG, OPND_DEST_MEM, 0));

        // shift-by-CL form fills slot 2 with CL
        gpr[1] = 32'h1F05;
        run("cl", 72'hC8D3, OPND_ENC_MODREGRM_RM_REG_CL, 4'b0000, 1'b0,
            0, 0, 0, 0, 0, 2,
            mk(32'h1234, 32'h1F05, 32'h05, 0,
               OPND_DEST_REG, OPND_DEST_REG, 0));

        // 16-bit operand size truncates registers
        gpr[0] = 32'hABCD_1234;
        gpr[3] = 32'h5566_7788;
        run("op16", 72'hD801, OPND_ENC_RM_REG, 4'b0010, 1'b0, 0, 0,
            0, 0, 0, 2, mk(32'h1234, 32'h7788, 0, 0,
                           OPND_DEST_REG, OPND_DEST_REG, 0));

        // disp32-only address followed by imm8 at offset 6
        run("disp32_imm", 72'h7F000020000583, OPND_ENC_RM_IMM, 4'b1000,
            1'b1, 32'h2000, 32'h1234_5678, 1, 0, 0, 0,
            mk(32'h1234_5678, 32'h7F, 0, 32'h2000,
               OPND_DEST_MEM, OPND_DEST_REG, 0));

        // byte-sized memory read and AL register
        run("mem_byte", 72'h2000058A, OPND_ENC_REG_RM, 4'b0100, 1'b1,
            32'h2000, 32'h1234_5678, 0, 0, 0, 0,
            mk(32'h34, 32'h78, 0, 32'h2000,
               OPND_DEST_REG, OPND_DEST_MEM, 0));

        // SIB with no index and no base: pure disp32
        run("sib_nobase", 72'h300025048B, OPND_ENC_REG_RM, 4'b0000, 1'b1,
            32'h3000, 32'hCAFE_F00D, 0, 2, 0, 0,
            mk(32'hABCD_1234, 32'hCAFE_F00D, 0, 32'h3000,
               OPND_DEST_REG, OPND_DEST_MEM, 0));

        // unsupported forms report err with zeroed operands
        run("disp_form", 72'h1234A1, OPND_ENC_DISP, 4'b0000, 1'b0, 0, 0,
            0, 0, 0, 2, mk(0, 0, 0, 0, OPND_DEST_REG, OPND_DEST_REG, 1));
        run("bad_form", 72'hD801, 4'hF, 4'b0000, 1'b0, 0, 0,
            0, 0, 1, 2, mk(0, 0, 0, 0, OPND_DEST_REG, OPND_DEST_REG, 1));

        // reset while waiting for a response, then a stale response
        gpr[0] = 32'h11;
        gpr[1] = 32'd2;
        gpr[3] = 32'h1000;
        unescaped_instr = 72'hFC8B448B;
        opnd_form = OPND_ENC_REG_RM;
        {imm_1byte, reg_1byte, prefix_operand_16bit,
         prefix_address_16bit} = 4'b0000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!mem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort/req", 96'(mem_req_valid), 96'd1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort/idle", 96'({in_ready, out_valid, mem_req_valid}),
            96'b100);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 32'hBAD0;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (out_valid || !in_ready || mem_req_valid)
                stable = 1'b0;
            @(negedge clk);
        end
        chk("abort/stale_rsp", 96'(stable), 96'd1);

        // normal operation resumes after the abort
        gpr[0] = 32'd5;
        gpr[3] = 32'd7;
        run("recover", 72'hD801, OPND_ENC_RM_REG, 4'b0000, 1'b0, 0, 0,
            0, 0, 0, 2, mk(5, 7, 0, 0, OPND_DEST_REG, OPND_DEST_REG, 0));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
